// File: rtl/alu_adder_64_seq.sv
// alu_adder_64_seq: multi-cycle 64-bit adder, CHUNK bits per cycle, valid/ready handshake; optional flags via ALU_ADD_CC_FLAGS_EN
module alu_adder_64_seq #(
  parameter int CHUNK = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] sum,
  output logic        cout,
  output logic        overflow
`ifdef ALU_ADD_CC_FLAGS_EN
  ,
  output logic        zf,
  output logic        sf
`endif
);
  localparam int NCYC = 64 / CHUNK;
  localparam int CW = NCYC > 1 ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);
  if (CHUNK != 1 && CHUNK != 2 && CHUNK != 4 && CHUNK != 8 &&
      CHUNK != 16 && CHUNK != 32 && CHUNK != 64) begin : g_bad_chunk
    $error("alu_adder_64_seq: CHUNK must be 1, 2, 4, 8, 16, 32 or 64");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [63:0] r_a, r_b, r_sum, w_nsum;
  logic [CW-1:0] r_cnt;
  logic r_carry, r_cout, r_ovf;
  logic [CHUNK-1:0] w_ca, w_cb;
  logic [CHUNK:0] w_s;
  logic w_last, w_c63in;
  assign w_ca = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_cb = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_s = {1'b0, w_ca} + {1'b0, w_cb} + {{CHUNK{1'b0}}, r_carry};
  assign w_last = r_cnt == LAST;
  // carry into the chunk's top bit, recovered from its sum bit and operand bits
  assign w_c63in = w_s[CHUNK-1] ^ w_ca[CHUNK-1] ^ w_cb[CHUNK-1];
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign sum = r_sum;
  assign cout = r_cout;
  assign overflow = r_ovf;
  // sum register with the current chunk result merged in
  always_comb begin
    w_nsum = r_sum;
    w_nsum[r_cnt*CHUNK +: CHUNK] = w_s[CHUNK-1:0];
  end
  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // operand capture and chunked add datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
      r_sum <= '0;
      r_cnt <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_a <= a;
      r_b <= b;
      r_carry <= cin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_sum <= w_nsum;
      r_carry <= w_s[CHUNK];
      if (w_last) begin
        r_cout <= w_s[CHUNK];
        r_ovf <= w_s[CHUNK] ^ w_c63in;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
`ifdef ALU_ADD_CC_FLAGS_EN
  logic r_zf, r_sf;
  assign zf = r_zf;
  assign sf = r_sf;
  // condition flags captured with the final chunk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_zf <= 1'b0;
      r_sf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_zf <= w_nsum == 64'd0;
      r_sf <= w_nsum[63];
    end
  end
`endif
endmodule

// File: tb/tb_alu_adder_64_seq.sv
// tb_alu_adder_64_seq: directed and random checks of the chunked adder at CHUNK=8, 1 and 64
module tb_alu_adder_64_seq;
  logic clk = 1'b0;
  logic rst, out_ready, cin;
  logic [63:0] a, b;
  logic [2:0] iv, ir, ov, co, of;
  logic [2:0][63:0] so;
`ifdef ALU_ADD_CC_FLAGS_EN
  logic [2:0] zf_o, sf_o;
`endif
  int total = 0;
  int bad = 0;
  int ncyc[3] = '{8, 64, 1};
  always #5 clk = ~clk;
  alu_adder_64_seq #(.CHUNK(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .sum(so[0]), .cout(co[0]), .overflow(of[0])
`ifdef ALU_ADD_CC_FLAGS_EN
    , .zf(zf_o[0]), .sf(sf_o[0])
`endif
  );
  alu_adder_64_seq #(.CHUNK(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .sum(so[1]), .cout(co[1]), .overflow(of[1])
`ifdef ALU_ADD_CC_FLAGS_EN
    , .zf(zf_o[1]), .sf(sf_o[1])
`endif
  );
  alu_adder_64_seq #(.CHUNK(64)) u64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b), .cin(cin),
    .out_valid(ov[2]), .out_ready(out_ready), .sum(so[2]), .cout(co[2]), .overflow(of[2])
`ifdef ALU_ADD_CC_FLAGS_EN
    , .zf(zf_o[2]), .sf(sf_o[2])
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_wait(input int s, input logic [63:0] x, input logic [63:0] y,
                            input logic c, input string tag);
    logic [64:0] full;
    logic exp_of;
    int n;
    full = {1'b0, x} + {1'b0, y} + 65'(c);
    exp_of = (x[63] == y[63]) && (full[63] != x[63]);
    chk({tag, "_idle_ready"}, 64'(ir[s]), 64'd1);
    a = x;
    b = y;
    cin = c;
    out_ready = 1'b0;
    iv[s] = 1'b1;
    @(posedge clk);
    #1;
    iv[s] = 1'b0;
    n = 0;
    while (!ov[s] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(ncyc[s]));
    chk({tag, "_sum"}, so[s], full[63:0]);
    chk({tag, "_cout"}, 64'(co[s]), 64'(full[64]));
    chk({tag, "_ovf"}, 64'(of[s]), 64'(exp_of));
    chk({tag, "_busy"}, 64'(ir[s]), 64'd0);
`ifdef ALU_ADD_CC_FLAGS_EN
    chk({tag, "_zf"}, 64'(zf_o[s]), 64'(full[63:0] == 64'd0));
    chk({tag, "_sf"}, 64'(sf_o[s]), 64'(full[63]));
`endif
  endtask

  task automatic release_out(input int s, input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_rel_ready"}, 64'(ir[s]), 64'd1);
    chk({tag, "_rel_valid"}, 64'(ov[s]), 64'd0);
  endtask

  task automatic run_op(input int s, input logic [63:0] x, input logic [63:0] y,
                        input logic c, input string tag);
    start_wait(s, x, y, c, tag);
    release_out(s, tag);
  endtask

  initial begin
    logic [63:0] x, y;
    int n;
    rst = 1'b1;
    iv = '0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir[0]), 64'd1);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_sum", so[0], 64'd0);
    chk("rst_cout", 64'(co[0]), 64'd0);
    chk("rst_ovf", 64'(of[0]), 64'd0);
    rst = 1'b0;
    run_op(0, 64'h5, 64'h3, 1'b0, "add5p3");
    run_op(0, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, "maxpos");
    run_op(0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, "wrapcin");
    run_op(0, 64'h8000000000000000, 64'h8000000000000000, 1'b0, "minmin");
    // backpressure: new operands offered while the result waits
    start_wait(0, 64'h1234, 64'h4321, 1'b1, "bp");
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
    a = x;
    b = y;
    cin = 1'b0;
    iv[0] = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_hold_sum", so[0], 64'h5556);
      chk("bp_hold_valid", 64'(ov[0]), 64'd1);
      chk("bp_hold_ready", 64'(ir[0]), 64'd0);
    end
    release_out(0, "bp");
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    chk("bp_next_taken", 64'(ir[0]), 64'd0);
    n = 0;
    while (!ov[0] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_next_latency", 64'(n), 64'd8);
    chk("bp_next_sum", so[0], x + y);
    release_out(0, "bp_next");
    // reset in the middle of an operation
    a = {$urandom, $urandom} | 64'h1;
    b = {$urandom, $urandom};
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(ov[0]), 64'd0);
    chk("midrst_ready", 64'(ir[0]), 64'd1);
    chk("midrst_sum", so[0], 64'd0);
    chk("midrst_cout", 64'(co[0]), 64'd0);
    chk("midrst_ovf", 64'(of[0]), 64'd0);
    #1;
    rst = 1'b0;
    run_op(0, 64'h5, 64'h3, 1'b0, "post_rst");
    run_op(1, 64'h5, 64'h3, 1'b0, "c1_add");
    run_op(2, 64'h5, 64'h3, 1'b0, "c64_add");
    run_op(1, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, "c1_negovf");
    run_op(2, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, 1'b1, "c64_posovf");
    for (int i = 0; i < 12; i++)
      run_op(0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rnd8");
    for (int i = 0; i < 3; i++)
      run_op(1, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rnd1");
    for (int i = 0; i < 4; i++)
      run_op(2, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), "rnd64");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
